timer_cmp_64: RTL
=================

TIMER_CMP_64 -- requirements
Module: timer_cmp_64

Interface
REQ-001 SHALL have: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have: count  in  64  free-running counter value from the upstream 64-bit up counter, sampled each clk.
REQ-004 SHALL have: wr_en  in  1  register write strobe, one write per asserted cycle.
REQ-005 SHALL have: rd_en  in  1  register read strobe, one read per asserted cycle.
REQ-006 SHALL have: addr  in  3  register index, shared by read and write.
REQ-007 SHALL have: wdata  in  32  write data.
REQ-008 SHALL have: rdata  out  32  read data, registered.
REQ-009 SHALL have: rd_valid  out  1  high for exactly one cycle when rdata holds a read result.
REQ-010 SHALL have: irq  out  1  timer interrupt, level, = pending AND ctrl.enable.

Function
REQ-011 SHALL decode the register map as: 0 CMP_LO, 1 CMP_HI, 2 CTRL{b0 enable, b1 periodic}, 3 STATUS{b0 pending, b1 ovf}, 4 SNAP_LO, 5 SNAP_HI, 6 PER_LO, 7 PER_HI.
REQ-012 SHALL make a write take effect at the clock edge of the wr_en cycle; a write to a half-register SHALL leave the other half unchanged.
REQ-013 SHALL treat STATUS writes as write-1-to-clear per bit; SNAP_LO and SNAP_HI writes SHALL be ignored.
REQ-014 SHALL return read data on rdata with rd_valid high in cycle N+1 for rd_en in cycle N; rdata SHALL hold its value when rd_valid is low.
REQ-015 SHALL return the pre-write register value when wr_en and rd_en target the same address in the same cycle.
REQ-016 SHALL, on a SNAP_LO read, return count[31:0] sampled in the rd_en cycle and latch count[63:32] of the same cycle into snap_hi.
REQ-017 SHALL return snap_hi on a SNAP_HI read, regardless of the intervening count changes.
REQ-018 SHALL implement the states IDLE, ARMED and DONE.
REQ-019 SHALL go to IDLE from any state when ctrl.enable=0; IDLE -> ARMED when enable becomes 1.
REQ-020 In ARMED, SHALL compare count >= cmp as unsigned 64-bit each cycle; on match, SHALL set pending at that edge.
REQ-021 On a match with periodic=0, or with periodic=1 and period=0, SHALL go to DONE.
REQ-022 On a match with periodic=1 and period!=0, SHALL load cmp <= cmp + period and stay in ARMED.
REQ-023 SHALL set STATUS.ovf and go to DONE, keeping the wrapped sum in cmp, if the reload sum carries out of bit 63.
REQ-024 In DONE, SHALL perform no compares; a write to CMP_LO, CMP_HI, or to CTRL with enable=1, SHALL return the state to ARMED.
REQ-025 SHALL use a CMP write in the same cycle as a reload in preference to the reload; the new value is compared from the next cycle.
REQ-026 SHALL keep pending (and ovf) set when a hardware set and a W1C clear coincide in the same cycle.
REQ-027 SHALL keep pending sticky until it is cleared by W1C; disabling masks irq but SHALL NOT clear pending.
REQ-028 SHALL accept no new write or read effects while reset is high; a transaction in flight at reset assertion SHALL be dropped (no rd_valid).

Reset
REQ-029 SHALL, on reset, clear: cmp=0, period=0, ctrl=0, pending=0, ovf=0, snap_hi=0, state=IDLE.
REQ-030 SHALL drive the outputs to rdata=0, rd_valid=0, irq=0 during and after reset, until a new event occurs.
REQ-031 SHALL resume normal operation on the first rising clk edge after reset deasserts.

Verification
REQ-032 One-shot: cmp=100, CTRL=1, count ramps 0.. -> pending and irq rise at the edge where count=100; state DONE; irq stays high until STATUS W1C 0x1, then irq=0.
REQ-033 Periodic: cmp=10, period=5, CTRL=3 -> pending set at count=10; CMP reads back 15, then 20 on the next match; irq is asserted again after each W1C clear.
REQ-034 Wrap: cmp=0xFFFF_FFFF_FFFF_FFF0, period=0x20, periodic, count reaches cmp -> ovf=1, cmp=0x10, state DONE, no further pending sets.
REQ-035 Snapshot: count=0x0000_0001_FFFF_FFFF at the SNAP_LO read -> rdata=0xFFFF_FFFF; a later SNAP_HI read returns 0x1 even though count has advanced.
REQ-036 Collision: W1C of pending in the same cycle as a new match -> pending stays 1; a read of CMP_LO in the same cycle as a write to CMP_LO returns the old value.
REQ-037 Mid-operation reset: reset asserted in the cycle after rd_en while ARMED -> no rd_valid, irq=0, all registers read 0 after deassertion.

Source files
------------

// File: rtl/timer_cmp_64.sv
// timer_cmp_64: 64-bit compare timer with one-shot/periodic reload, W1C status
// and a split snapshot of the free-running count for atomic 64-bit reads.
module timer_cmp_64 (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] count,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rd_valid,
  output logic        irq
);
  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;
  state_t state, state_nx;
  logic [63:0] cmp, period;
  logic [64:0] sum;
  logic [31:0] snap_hi, rd_mux;
  logic enable, periodic, pending, ovf;
  logic cmp_wr, arm_wr, clr_pend, clr_ovf, hit, reload, wrap;

  assign sum      = {1'b0, cmp} + {1'b0, period};
  assign cmp_wr   = wr_en && addr[2:1] == 2'b00;
  assign arm_wr   = cmp_wr || (wr_en && addr == 3'd2 && wdata[0]);
  assign clr_pend = wr_en && addr == 3'd3 && wdata[0];
  assign clr_ovf  = wr_en && addr == 3'd3 && wdata[1];
  assign irq      = pending && enable;

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;

  // A CMP write in the match cycle overrides both the reload and the move to DONE.
  always_comb
    state_nx = !enable ? IDLE :
               state == IDLE ? ARMED :
               state == ARMED ? ((hit && !cmp_wr && (!reload || wrap)) ? DONE : ARMED) :
               arm_wr ? ARMED : DONE;

  always_comb begin
    hit    = state == ARMED && count >= cmp;
    reload = hit && !cmp_wr && periodic && |period;
    wrap   = reload && sum[64];
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      3'd0: rd_mux = cmp[31:0];
      3'd1: rd_mux = cmp[63:32];
      3'd2: rd_mux = {30'd0, periodic, enable};
      3'd3: rd_mux = {30'd0, ovf, pending};
      3'd4: rd_mux = count[31:0];
      3'd5: rd_mux = snap_hi;
      3'd6: rd_mux = period[31:0];
      3'd7: rd_mux = period[63:32];
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cmp      <= '0;
      period   <= '0;
      enable   <= 1'b0;
      periodic <= 1'b0;
      pending  <= 1'b0;
      ovf      <= 1'b0;
      snap_hi  <= '0;
      rdata    <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_en && addr == 3'd0) cmp[31:0] <= wdata;
      else if (wr_en && addr == 3'd1) cmp[63:32] <= wdata;
      else if (reload) cmp <= sum[63:0];
      if (wr_en && addr == 3'd2) {periodic, enable} <= wdata[1:0];
      if (wr_en && addr == 3'd6) period[31:0] <= wdata;
      if (wr_en && addr == 3'd7) period[63:32] <= wdata;
      pending  <= hit || (pending && !clr_pend);
      ovf      <= wrap || (ovf && !clr_ovf);
      rd_valid <= rd_en;
      if (rd_en) rdata <= rd_mux;
      if (rd_en && addr == 3'd4) snap_hi <= count[63:32];
    end
endmodule
